// File: rtl/hilo_muldiv_if.sv
// EX-stage handshake to the HI/LO multiply/divide unit.
// master = EX stage, slave = hilo_muldiv.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic [2:0]           op_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 annul_i;
    logic                 hi_we_i;
    logic                 lo_we_i;
    logic [WIDTH-1:0]     hilo_wdata_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 dz_o;
    logic [2*WIDTH-1:0]   result_o;
    logic [WIDTH-1:0]     hi_o;
    logic [WIDTH-1:0]     lo_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, annul_i, hi_we_i, lo_we_i, hilo_wdata_i,
        input  busy_o, done_o, dz_o, result_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, annul_i, hi_we_i, lo_we_i, hilo_wdata_i,
        output busy_o, done_o, dz_o, result_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO pair: radix-2^MUL_STEP
// shift-add multiply, 1-bit restoring divide, sign fix-up on completion.
module hilo_muldiv #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic          clk,
    input  logic          rst,
    hilo_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 is_div;
    logic                 neg_q;
    logic                 neg_r;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     opb;
    logic                 done_q;
    logic                 dz_q;
    logic [2*WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    // Launch decode
    logic                 op_valid;
    logic                 div_in;
    logic                 signed_in;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic                 start_ok;

    always_comb begin
        op_valid  = (bus.op_i == OP_MULT) || (bus.op_i == OP_MULTU) ||
                    (bus.op_i == OP_DIV)  || (bus.op_i == OP_DIVU);
        div_in    = (bus.op_i == OP_DIV)  || (bus.op_i == OP_DIVU);
        signed_in = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
        a_neg     = signed_in & bus.opdata1_i[WIDTH-1];
        b_neg     = signed_in & bus.opdata2_i[WIDTH-1];
        a_abs     = a_neg ? -bus.opdata1_i : bus.opdata1_i;
        b_abs     = b_neg ? -bus.opdata2_i : bus.opdata2_i;
        start_ok  = (state == IDLE) && bus.start_i && op_valid;
    end

    // One iteration of either datapath, plus the sign-corrected final value
    logic [2*WIDTH-1:0]   mul_add;
    logic [2*WIDTH-1:0]   mul_nxt;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   div_nxt;
    logic [2*WIDTH-1:0]   step_nxt;
    logic [WIDTH-1:0]     q_fix;
    logic [WIDTH-1:0]     r_fix;
    logic [2*WIDTH-1:0]   fin;

    always_comb begin
        mul_add = '0;
        for (int k = 0; k < MUL_STEP; k++) begin
            if (opb[k]) mul_add = mul_add + (mcand << k);
        end
        mul_nxt = acc + mul_add;

        // Remainder lives in acc's upper half, dividend/quotient in the lower half
        rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff   = rem_sh - {1'b0, opb};
        if (!diff[WIDTH]) div_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else              div_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

        step_nxt = is_div ? div_nxt : mul_nxt;

        q_fix = neg_q ? -step_nxt[WIDTH-1:0] : step_nxt[WIDTH-1:0];
        r_fix = neg_r ? -step_nxt[2*WIDTH-1:WIDTH] : step_nxt[2*WIDTH-1:WIDTH];
        if (is_div) fin = {r_fix, q_fix};
        else        fin = neg_q ? -step_nxt : step_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            opb    <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            res_q  <= '0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            res_q  <= '0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        is_div <= div_in;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        opb    <= b_abs;
                        mcand  <= {{WIDTH{1'b0}}, a_abs};
                        acc    <= div_in ? {{WIDTH{1'b0}}, a_abs} : '0;
                        if (div_in && (bus.opdata2_i == '0)) begin
                            state  <= DONE;
                            cnt    <= '0;
                            done_q <= 1'b1;
                            dz_q   <= 1'b1;
                            res_q  <= {bus.opdata1_i, {WIDTH{1'b1}}};
                        end else begin
                            state  <= CALC;
                            cnt    <= div_in ? CW'(WIDTH) : CW'(WIDTH / MUL_STEP);
                        end
                    end
                end
                CALC: begin
                    if (bus.annul_i) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        acc <= step_nxt;
                        cnt <= cnt - 1'b1;
                        if (!is_div) begin
                            opb   <= opb >> MUL_STEP;
                            mcand <= mcand << MUL_STEP;
                        end
                        if (cnt == CW'(1)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            res_q  <= fin;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // A completing operation takes priority over MTHI/MTLO on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if ((state == DONE) && !bus.annul_i) begin
            hi_q <= res_q[2*WIDTH-1:WIDTH];
            lo_q <= res_q[WIDTH-1:0];
        end else begin
            if (bus.hi_we_i) hi_q <= bus.hilo_wdata_i;
            if (bus.lo_we_i) lo_q <= bus.hilo_wdata_i;
        end
    end

    assign bus.busy_o   = (state != IDLE) || start_ok;
    assign bus.done_o   = done_q;
    assign bus.dz_o     = dz_q;
    assign bus.result_o = res_q;
    assign bus.hi_o     = hi_q;
    assign bus.lo_o     = lo_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv; three instances (MUL_STEP 1/2/4) share one
// stimulus bus, instance 1 (MUL_STEP=2) is the primary one.
module tb_hilo_muldiv;
    localparam int W = 32;
    localparam logic [2:0] MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011, DIVU = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic [2:0]   op    = '0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         annul = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;

    logic [2:0]            busy_v, done_v, dz_v;
    logic [2:0][2*W-1:0]   res_v;
    logic [2:0][W-1:0]     hi_v, lo_v;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hilo_muldiv_if #(.WIDTH(W)) bus ();
        assign bus.start_i      = start;
        assign bus.op_i         = op;
        assign bus.opdata1_i    = a;
        assign bus.opdata2_i    = b;
        assign bus.annul_i      = annul;
        assign bus.hi_we_i      = hi_we;
        assign bus.lo_we_i      = lo_we;
        assign bus.hilo_wdata_i = wdata;
        assign busy_v[g] = bus.busy_o;
        assign done_v[g] = bus.done_o;
        assign dz_v[g]   = bus.dz_o;
        assign res_v[g]  = bus.result_o;
        assign hi_v[g]   = bus.hi_o;
        assign lo_v[g]   = bus.lo_o;
        hilo_muldiv #(.WIDTH(W), .MUL_STEP(1 << g)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    wire           busy = busy_v[1];
    wire           done = done_v[1];
    wire           dz   = dz_v[1];
    wire [2*W-1:0] res  = res_v[1];
    wire [W-1:0]   hi   = hi_v[1];
    wire [W-1:0]   lo   = lo_v[1];

    int checks = 0;
    int passes = 0;

    // Called just after a negedge; returns at the negedge of cycle 1
    task automatic launch(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'b000; a = $urandom; b = $urandom;
    endtask

    // Steps negedge by negedge until done is seen or the budget runs out
    task automatic wait_done(input int c0, output int lat);
        lat = c0;
        while (done !== 1'b1 && lat < 80) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        checks++; if ({hi, lo} !== '0) $display("FAIL reset_hilo: got %h want 0", {hi, lo}); else passes++;
        checks++; if (res !== '0) $display("FAIL reset_result: got %h want 0", res); else passes++;
        checks++; if ({busy, done, dz} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, dz}); else passes++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int lat;
        start = 1'b1; op = MULT; a = 32'hFFFF_FFFD; b = 32'd5;
        #1;
        checks++; if (busy !== 1'b1) $display("FAIL busy_on_start: got %b want 1", busy); else passes++;
        launch(MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(1, lat);
        checks++; if (lat !== 17) $display("FAIL mult_latency: got %0d want 17", lat); else passes++;
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFF1) $display("FAIL mult_result: got %h want FFFFFFFFFFFFFFF1", res); else passes++;
        checks++; if (dz !== 1'b0) $display("FAIL mult_dz: got %b want 0", dz); else passes++;
        @(negedge clk);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) $display("FAIL mult_hilo: got %h want FFFFFFFFFFFFFFF1", {hi, lo}); else passes++;
        checks++; if ({busy, done} !== 2'b00) $display("FAIL mult_idle_flags: got %b want 00", {busy, done}); else passes++;
        checks++; if (res !== '0) $display("FAIL mult_result_cleared: got %h want 0", res); else passes++;
    endtask

    task automatic test_div();
        int lat;
        launch(DIVU, 32'd100, 32'd7);
        wait_done(1, lat);
        checks++; if (lat !== 33) $display("FAIL divu_latency: got %0d want 33", lat); else passes++;
        checks++; if (res !== {32'h2, 32'hE}) $display("FAIL divu_result: got %h want 000000020000000E", res); else passes++;
        @(negedge clk);
        launch(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, lat);
        checks++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) $display("FAIL div_signed: got %h want FFFFFFFFFFFFFFFD", res); else passes++;
        @(negedge clk);
        launch(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, lat);
        checks++; if (res !== {32'h0, 32'h8000_0000}) $display("FAIL div_overflow: got %h want 0000000080000000", res); else passes++;
        checks++; if (dz !== 1'b0) $display("FAIL div_overflow_dz: got %b want 0", dz); else passes++;
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat;
        launch(DIVU, 32'd5, 32'd0);
        wait_done(1, lat);
        checks++; if (lat !== 1) $display("FAIL dz_latency: got %0d want 1", lat); else passes++;
        checks++; if (dz !== 1'b1) $display("FAIL dz_flag: got %b want 1", dz); else passes++;
        checks++; if (res !== {32'd5, 32'hFFFF_FFFF}) $display("FAIL dz_result: got %h want 00000005FFFFFFFF", res); else passes++;
        @(negedge clk);
        checks++; if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) $display("FAIL dz_hilo: got %h want 00000005FFFFFFFF", {hi, lo}); else passes++;
    endtask

    task automatic test_annul();
        int lat;
        logic seen = 1'b0;
        launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int c = 1; c < 8; c++) begin
            if (done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        annul = 1'b1;
        if (done === 1'b1) seen = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL annul_idle: got busy %b want 0", busy); else passes++;
        checks++; if (seen !== 1'b0) $display("FAIL annul_no_done: got %b want 0", seen); else passes++;
        checks++; if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) $display("FAIL annul_hilo_kept: got %h want 00000005FFFFFFFF", {hi, lo}); else passes++;
        launch(MULTU, 32'd2, 32'd3);
        wait_done(1, lat);
        checks++; if (lat !== 17) $display("FAIL annul_restart_latency: got %0d want 17", lat); else passes++;
        @(negedge clk);
        checks++; if ({hi, lo} !== {32'd0, 32'd6}) $display("FAIL annul_restart_hilo: got %h want 0000000000000006", {hi, lo}); else passes++;
    endtask

    task automatic test_mt_conflict();
        int lat;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        checks++; if ({hi, lo} !== {32'h55, 32'h55}) $display("FAIL mt_idle: got %h want 0000005500000055", {hi, lo}); else passes++;
        launch(MULTU, 32'd2, 32'd3);
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'hABCD;
        @(negedge clk);
        hi_we = 1'b0;
        checks++; if ({hi, lo} !== {32'hABCD, 32'h55}) $display("FAIL mthi_calc: got %h want 0000ABCD00000055", {hi, lo}); else passes++;
        wait_done(3, lat);
        lo_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        lo_we = 1'b0;
        checks++; if ({hi, lo} !== {32'd0, 32'd6}) $display("FAIL mt_conflict: got %h want 0000000000000006", {hi, lo}); else passes++;
    endtask

    task automatic test_back_to_back();
        int lat;
        launch(MULT, 32'd7, 32'hFFFF_FFFA);
        wait_done(1, lat);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFD6) $display("FAIL b2b_first: got %h want FFFFFFFFFFFFFFD6", res); else passes++;
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy: got %b want 0", busy); else passes++;
        launch(MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(1, lat);
        checks++; if (lat !== 17) $display("FAIL b2b_latency: got %0d want 17", lat); else passes++;
        checks++; if (res !== 64'h4000_0000_0000_0000) $display("FAIL b2b_second: got %h want 4000000000000000", res); else passes++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        launch(DIV, 32'd100, 32'd7);
        for (int c = 1; c < 10; c++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if ({hi, lo} !== '0) $display("FAIL rst_mid_hilo: got %h want 0", {hi, lo}); else passes++;
        checks++; if ({busy, done, dz} !== 3'b000) $display("FAIL rst_mid_flags: got %b want 000", {busy, done, dz}); else passes++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL rst_release_busy: got %b want 0", busy); else passes++;
        launch(DIVU, 32'd100, 32'd7);
        wait_done(1, lat);
        checks++; if (lat !== 33) $display("FAIL rst_restart_latency: got %0d want 33", lat); else passes++;
        checks++; if (res !== {32'h2, 32'hE}) $display("FAIL rst_restart_result: got %h want 000000020000000E", res); else passes++;
        @(negedge clk);
    endtask

    task automatic test_step_sweep();
        logic [2:0]     vop [4] = '{MULTU, MULT, MULTU, MULT};
        logic [W-1:0]   va  [4] = '{32'hFFFF_FFFF, 32'd7, 32'h0001_0000, 32'hFFFF_FFFF};
        logic [W-1:0]   vb  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0001_0000, 32'hFFFF_FFFF};
        logic [2*W-1:0] vexp[4] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFD6,
                                    64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001};
        for (int v = 0; v < 4; v++) begin
            int lat1 = 0, lat4 = 0;
            logic [2*W-1:0] r1 = '0, r4 = '0;
            launch(vop[v], va[v], vb[v]);
            for (int c = 1; c <= 40; c++) begin
                if (done_v[0] === 1'b1 && lat1 == 0) begin lat1 = c; r1 = res_v[0]; end
                if (done_v[2] === 1'b1 && lat4 == 0) begin lat4 = c; r4 = res_v[2]; end
                @(negedge clk);
            end
            checks++; if (lat1 !== 33) $display("FAIL step1_latency[%0d]: got %0d want 33", v, lat1); else passes++;
            checks++; if (lat4 !== 9) $display("FAIL step4_latency[%0d]: got %0d want 9", v, lat4); else passes++;
            checks++; if (r1 !== vexp[v]) $display("FAIL step1_product[%0d]: got %h want %h", v, r1, vexp[v]); else passes++;
            checks++; if (r4 !== vexp[v]) $display("FAIL step4_product[%0d]: got %h want %h", v, r4, vexp[v]); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_annul();
        test_mt_conflict();
        test_back_to_back();
        test_reset_mid();
        test_step_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
